uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_core.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART core: state encoding and default frame geometry.
package uart_pkg;

    localparam int DEFAULT_DATAWIDTH    = 8;
    localparam int DEFAULT_OVERSAMPLING = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clk tick every div clocks (div of 0 or 1 ticks every clock).
// clear holds the phase at zero so the first tick lands exactly div clocks after release.
module uart_baud_gen #(
    parameter int DIVWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIVWIDTH-1:0] div,
    input  logic                clear,
    output logic                tick
);

    logic [DIVWIDTH-1:0] cnt;
    logic [DIVWIDTH-1:0] last;

    assign last = (div > DIVWIDTH'(1)) ? div - DIVWIDTH'(1) : '0;
    assign tick = !clear && (cnt >= last);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with independent TX/RX baud generators.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATAWIDTH    = DEFAULT_DATAWIDTH,
    parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
    parameter int DIVWIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIVWIDTH-1:0]  div,
    input  logic                 parityEnable,
    input  logic                 parityType,
    input  logic                 tx_data_valid,
    input  logic [DATAWIDTH-1:0] tx_in,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATAWIDTH-1:0] rx_out,
    output logic                 parityError,
    output logic                 parityErrorValid,
    output logic                 rx_done,
    output logic                 framingError
);

    localparam int TW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATAWIDTH - 1);

    logic par_en_cfg;
    logic par_odd_cfg;

`ifdef UART_PARITY_EN
    assign par_en_cfg  = parityEnable;
    assign par_odd_cfg = parityType;
`else
    logic unused_parity_cfg;
    assign par_en_cfg        = 1'b0;
    assign par_odd_cfg       = 1'b0;
    assign unused_parity_cfg = parityEnable ^ parityType;
`endif

    // ---------------- transmitter ----------------
    uart_state_e          tx_state, tx_next;
    logic                 tx_tick, tx_bit_done;
    logic [TW-1:0]        tx_tick_cnt;
    logic [BW-1:0]        tx_bit_idx;
    logic [DATAWIDTH-1:0] tx_shift;
    logic                 tx_par_en, tx_par_bit;

    uart_baud_gen #(.DIVWIDTH(DIVWIDTH)) u_tx_baud (
        .clk   (clk),
        .rst   (rst),
        .div   (div),
        .clear (tx_state == ST_IDLE),
        .tick  (tx_tick)
    );

    assign tx_bit_done = tx_tick && (tx_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= ST_IDLE;
        else      tx_state <= tx_next;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:   if (tx_data_valid) tx_next = ST_START;
            ST_START:  if (tx_bit_done) tx_next = ST_DATA;
            ST_DATA:   if (tx_bit_done && tx_bit_idx == BIT_LAST)
                           tx_next = tx_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tx_bit_done) tx_next = ST_STOP;
            ST_STOP:   if (tx_bit_done) tx_next = ST_IDLE;
            default:   tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx      = 1'b1;
        tx_done = 1'b0;
        case (tx_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = tx_shift[0];
            ST_PARITY: tx = tx_par_bit;
            ST_STOP:   tx_done = tx_bit_done;
            default:   ;
        endcase
    end

    // NOTE: datapath registers are reset as well, so nothing leaves reset carrying X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
        end else if (tx_state == ST_IDLE) begin
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            if (tx_data_valid) begin
                tx_shift   <= tx_in;
                tx_par_en  <= par_en_cfg;
                tx_par_bit <= (^tx_in) ^ par_odd_cfg;
            end
        end else if (tx_tick) begin
            tx_tick_cnt <= tx_bit_done ? '0 : tx_tick_cnt + 1'b1;
            if (tx_bit_done && tx_state == ST_DATA) begin
                tx_shift   <= tx_shift >> 1;
                tx_bit_idx <= tx_bit_idx + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    uart_state_e          rx_state, rx_next;
    logic                 rx_meta, rx_sync, rx_prev, rx_fall;
    logic                 rx_tick, rx_bit_done, rx_mid_hit;
    logic [TW-1:0]        rx_tick_cnt;
    logic [BW-1:0]        rx_bit_idx;
    logic [DATAWIDTH-1:0] rx_shift, rx_word;
    logic                 rx_par_en, rx_par_odd;
    logic                 rx_clear, rx_load, rx_check_par, rx_end;

    uart_baud_gen #(.DIVWIDTH(DIVWIDTH)) u_rx_baud (
        .clk   (clk),
        .rst   (rst),
        .div   (div),
        .clear (rx_state == ST_IDLE),
        .tick  (rx_tick)
    );

    assign rx_fall     = rx_prev & ~rx_sync;
    assign rx_bit_done = rx_tick && (rx_tick_cnt == TICK_LAST);
    assign rx_mid_hit  = rx_tick && (rx_tick_cnt == TICK_MID);
    assign rx_word     = {rx_sync, rx_shift[DATAWIDTH-1:1]};

    // Two-flop synchroniser plus one history flop for edge detection; idle level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= ST_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:   if (rx_fall) rx_next = ST_START;
            ST_START:  if (rx_mid_hit) rx_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_bit_done && rx_bit_idx == BIT_LAST)
                           rx_next = rx_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (rx_bit_done) rx_next = ST_STOP;
            ST_STOP:   if (rx_bit_done) rx_next = ST_IDLE;
            default:   rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_clear     = 1'b0;
        rx_load      = 1'b0;
        rx_check_par = 1'b0;
        rx_end       = 1'b0;
        case (rx_state)
            ST_START:  rx_clear     = rx_mid_hit && !rx_sync;
            ST_DATA:   rx_load      = rx_bit_done && rx_bit_idx == BIT_LAST && !rx_par_en;
            ST_PARITY: rx_check_par = rx_bit_done;
            ST_STOP:   rx_end       = rx_bit_done;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_tick_cnt      <= '0;
            rx_bit_idx       <= '0;
            rx_shift         <= '0;
            rx_par_en        <= 1'b0;
            rx_par_odd       <= 1'b0;
            rx_out           <= '0;
            parityError      <= 1'b0;
            parityErrorValid <= 1'b0;
            framingError     <= 1'b0;
            rx_done          <= 1'b0;
        end else begin
            rx_done <= rx_end;
            if (rx_state == ST_IDLE) begin
                rx_tick_cnt <= '0;
                rx_bit_idx  <= '0;
                if (rx_fall) begin
                    rx_par_en  <= par_en_cfg;
                    rx_par_odd <= par_odd_cfg;
                end
            end else if (rx_tick) begin
                // START counts only to mid-bit; later states count whole bits from there.
                if (rx_bit_done || (rx_state == ST_START && rx_mid_hit))
                    rx_tick_cnt <= '0;
                else
                    rx_tick_cnt <= rx_tick_cnt + 1'b1;
                if (rx_bit_done && rx_state == ST_DATA) begin
                    rx_shift   <= rx_word;
                    rx_bit_idx <= rx_bit_idx + 1'b1;
                end
            end
            if (rx_clear) begin
                parityError      <= 1'b0;
                parityErrorValid <= 1'b0;
                framingError     <= 1'b0;
            end
            if (rx_load) rx_out <= rx_word;
            if (rx_check_par) begin
                rx_out           <= rx_shift;
                parityErrorValid <= 1'b1;
                parityError      <= rx_sync != ((^rx_shift) ^ rx_par_odd);
            end
            if (rx_end) framingError <= ~rx_sync;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: TX instance (625 ns clk, div 20) feeds RX instance (1250 ns clk, div 10),
// with a bench-driven line override for corrupted frames.
`timescale 1ns/1ps
module tb_uart_core;
    import uart_pkg::*;

`ifdef UART_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int BIT_NS      = 200_000;
    localparam int TX_BIT_CLKS = 320;

    logic clk_tx = 1'b0, clk_rx = 1'b0, rst = 1'b0;
    logic parity_en = 1'b0, parity_odd = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic line_force = 1'b0, line_bit = 1'b1, line;
    logic tx_line, tx_done_a;
    logic [7:0] unused_rx_out_a, rx_out_b;
    logic unused_pe_a, unused_pev_a, unused_rxd_a, unused_fe_a;
    logic unused_tx_b, unused_txd_b, pe_b, pev_b, rxd_b, fe_b;
    int tests = 0, failed = 0, tx_done_cnt = 0, rx_done_cnt = 0;

    assign line = line_force ? line_bit : tx_line;

    always #312.5 clk_tx = ~clk_tx;
    always #625   clk_rx = ~clk_rx;

    uart_core u_tx (
        .clk(clk_tx), .rst(rst), .div(16'd20),
        .parityEnable(parity_en), .parityType(parity_odd),
        .tx_data_valid(tx_valid), .tx_in(tx_data),
        .tx(tx_line), .tx_done(tx_done_a),
        .rx(1'b1), .rx_out(unused_rx_out_a),
        .parityError(unused_pe_a), .parityErrorValid(unused_pev_a),
        .rx_done(unused_rxd_a), .framingError(unused_fe_a)
    );

    uart_core u_rx (
        .clk(clk_rx), .rst(rst), .div(16'd10),
        .parityEnable(parity_en), .parityType(parity_odd),
        .tx_data_valid(1'b0), .tx_in(8'h00),
        .tx(unused_tx_b), .tx_done(unused_txd_b),
        .rx(line), .rx_out(rx_out_b),
        .parityError(pe_b), .parityErrorValid(pev_b),
        .rx_done(rxd_b), .framingError(fe_b)
    );

    always @(negedge clk_tx) if (tx_done_a === 1'b1) tx_done_cnt++;
    always @(negedge clk_rx) if (rxd_b === 1'b1) rx_done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s: check did not hold", tag);
        end
    endtask

    // Sends one frame through the TX instance; cycles = clk_tx negedges from acceptance to tx_done.
    task automatic send_tx(input logic [7:0] data, input logic pen, input logic podd,
                           input bit inject, output int cycles);
        parity_en  = pen;
        parity_odd = podd;
        tx_data    = data;
        @(negedge clk_tx);
        tx_valid = 1'b1;
        @(negedge clk_tx);
        tx_valid = 1'b0;
        cycles = 1;
        while (tx_done_a !== 1'b1 && cycles < 5000) begin
            @(negedge clk_tx);
            cycles++;
            tx_valid = inject && (cycles == 1000);
            if (inject && cycles == 1000) tx_data = 8'h00;
        end
        tx_valid = 1'b0;
    endtask

    // Drives a raw frame (LSB first) straight onto the RX line, then one idle bit.
    task automatic send_raw(input logic [11:0] bits, input int n);
        line_bit   = 1'b1;
        line_force = 1'b1;
        for (int i = 0; i < n; i++) begin
            line_bit = bits[i];
            #(BIT_NS);
        end
        line_bit = 1'b1;
        #(BIT_NS);
        line_force = 1'b0;
    endtask

    initial begin
        int cyc, r0, d0;
        logic [11:0] raw;

        // Reset values
        #2000;
        check("rst_tx_line", tx_line, 1);
        check("rst_tx_done", tx_done_a, 0);
        check("rst_rx_out", rx_out_b, 0);
        check("rst_pev", pev_b, 0);
        check("rst_pe", pe_b, 0);
        check("rst_fe", fe_b, 0);
        check("rst_rx_done", rxd_b, 0);
        @(negedge clk_tx);
        rst = 1'b1;
        #20000;

        // 0xDB even parity, with a stray tx_data_valid mid-frame that must be ignored
        r0 = rx_done_cnt;
        send_tx(8'hDB, 1'b1, 1'b0, 1'b1, cyc);
        #1000;
        check("t1_len", cyc, (PAR_BUILD ? 11 : 10) * TX_BIT_CLKS);
        check("t1_rx_out", rx_out_b, 8'hDB);
        check("t1_pev", pev_b, PAR_BUILD);
        check("t1_pe", pe_b, 0);
        check("t1_fe", fe_b, 0);
        check("t1_rx_done", rx_done_cnt - r0, 1);
        #20000;

        // 0xF1 even parity (parity bit 1 on the line)
        r0 = rx_done_cnt;
        send_tx(8'hF1, 1'b1, 1'b0, 1'b0, cyc);
        #1000;
        check("t2_len", cyc, (PAR_BUILD ? 11 : 10) * TX_BIT_CLKS);
        check("t2_rx_out", rx_out_b, 8'hF1);
        check("t2_pe", pe_b, 0);
        check("t2_rx_done", rx_done_cnt - r0, 1);
        #20000;

        // 0x81 parity disabled: 10-bit frame
        r0 = rx_done_cnt;
        send_tx(8'h81, 1'b0, 1'b0, 1'b0, cyc);
        #1000;
        check("t3_len", cyc, 10 * TX_BIT_CLKS);
        check("t3_rx_out", rx_out_b, 8'h81);
        check("t3_pev", pev_b, 0);
        check("t3_rx_done", rx_done_cnt - r0, 1);
        #20000;

        // 0xA5 odd parity: correct bit is 1, line carries 0. Without parity support
        // that bit is taken as the stop bit, so a framing error is expected instead.
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        raw = {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        r0 = rx_done_cnt;
        send_raw(raw, 11);
        #20000;
        check("t4_rx_out", rx_out_b, 8'hA5);
        check("t4_pev", pev_b, PAR_BUILD);
        check("t4_pe", pe_b, PAR_BUILD);
        check("t4_fe", fe_b, !PAR_BUILD);
        check("t4_rx_done", rx_done_cnt - r0, 1);

        // 0x3C with the stop bit driven low
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        raw = {2'b00, 1'b0, 8'h3C, 1'b0};
        r0 = rx_done_cnt;
        send_raw(raw, 10);
        #20000;
        check("t5_rx_out", rx_out_b, 8'h3C);
        check("t5_fe", fe_b, 1);
        check("t5_pev", pev_b, 0);
        check("t5_rx_done", rx_done_cnt - r0, 1);
        check("t5_rx_idle", u_rx.rx_state, ST_IDLE);

        // Clean frame clears the framing flag
        r0 = rx_done_cnt;
        send_tx(8'h66, 1'b0, 1'b0, 1'b0, cyc);
        #1000;
        check("t5b_rx_out", rx_out_b, 8'h66);
        check("t5b_fe", fe_b, 0);
        check("t5b_rx_done", rx_done_cnt - r0, 1);
        #20000;

        // Reset during TX data bit 3 of 0xC3 (a 0 on the line)
        tx_data   = 8'hC3;
        parity_en = 1'b0;
        @(negedge clk_tx);
        tx_valid = 1'b1;
        @(negedge clk_tx);
        tx_valid = 1'b0;
        repeat (1500) @(negedge clk_tx);
        d0 = tx_done_cnt;
        check("t6_pre_tx_low", tx_line, 0);
        #100 rst = 1'b0;
        #1;
        check("t6_tx_high", tx_line, 1);
        check("t6_tx_idle", u_tx.tx_state, ST_IDLE);
        check("t6_rx_out_clr", rx_out_b, 0);
        repeat (10) @(negedge clk_tx);
        rst = 1'b1;
        repeat (4000) @(negedge clk_tx);
        check("t6_no_done", tx_done_cnt - d0, 0);
        check("t6_line_idle", tx_line, 1);
        r0 = rx_done_cnt;
        send_tx(8'h5A, 1'b0, 1'b0, 1'b0, cyc);
        #1000;
        check("t6_len", cyc, 10 * TX_BIT_CLKS);
        check("t6_rx_out", rx_out_b, 8'h5A);
        check("t6_rx_done", rx_done_cnt - r0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
